// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state, phase and opcode definitions for the SPI slave front end
package spi_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_e;

    // Sub-phase inside WRITE/READ_ADD/READ_DATA
    typedef enum logic [1:0] {
        PH_RX      = 2'd0,
        PH_WAIT_TX = 2'd1,
        PH_TX      = 2'd2,
        PH_HOLD    = 2'd3
    } spi_phase_e;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_if_if.sv
// rtl/spi_slave_if_if.sv - frame/read-data handshake between the SPI front end and the RAM block
interface spi_slave_if_if #(
    parameter int DATA_W = 8
);
    localparam int FRAME_W = DATA_W + 2;

    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport slave  (output rx_data, rx_valid, input  tx_data, tx_valid);
    modport master (input  rx_data, rx_valid, output tx_data, tx_valid);
endinterface

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - SIPO/PISO shift register with bit counter and last-bit flags
module spi_shift_reg #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 shift_en,
    input  logic                 din,
    input  logic                 load,
    input  logic [DATA_W-1:0]    load_data,
    output logic [DATA_W+1:0]    frame_next,
    output logic                 ser_out,
    output logic                 rx_done,
    output logic                 tx_done
);
    localparam int FRAME_W = DATA_W + 2;

    logic [FRAME_W-1:0] sreg;
    logic [CNT_W-1:0]   cnt;

    assign frame_next = {sreg[FRAME_W-2:0], din};
    assign ser_out    = sreg[FRAME_W-1];
    assign rx_done    = shift_en && (cnt == CNT_W'(FRAME_W - 1));
    assign tx_done    = shift_en && (cnt == CNT_W'(DATA_W - 1));

    // Transmit data sits left-aligned so the same MSB tap feeds MISO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (clr) begin
            cnt  <= '0;
        end else if (load) begin
            sreg <= {load_data, {(FRAME_W - DATA_W){1'b0}}};
            cnt  <= '0;
        end else if (shift_en) begin
            sreg <= frame_next;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI mode-0 slave front end; SPI_FRAME_ERR_EN adds the frame_err output
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           SS_n,
    input  logic           MOSI,
    output logic           MISO,
    spi_slave_if_if.slave  ram
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic           frame_err
`endif
);
    localparam int FRAME_W = DATA_W + 2;

    spi_state_e         state_q, state_d;
    spi_phase_e         phase_q, phase_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rd_seen_q, rd_seen_d;
    logic               miso_d;
    logic               err_d;

    logic               sr_clr, sr_shift, sr_din, sr_load;
    logic [FRAME_W-1:0] frame_next;
    logic               ser_out, rx_done, tx_done;

    spi_shift_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (sr_clr),
        .shift_en   (sr_shift),
        .din        (sr_din),
        .load       (sr_load),
        .load_data  (ram.tx_data),
        .frame_next (frame_next),
        .ser_out    (ser_out),
        .rx_done    (rx_done),
        .tx_done    (tx_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= PH_RX;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rd_seen_q  <= 1'b0;
            MISO       <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rd_seen_q  <= rd_seen_d;
            MISO       <= miso_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rd_seen_d  = rd_seen_q;
        miso_d     = 1'b0;
        err_d      = 1'b0;
        sr_clr     = 1'b0;
        sr_shift   = 1'b0;
        sr_din     = MOSI;
        sr_load    = 1'b0;

        // Deselect wins over everything, including a frame's final bit
        if (SS_n) begin
            state_d = IDLE;
            phase_d = PH_RX;
            sr_clr  = 1'b1;
            if (state_q == CHK_CMD ||
                ((state_q == WRITE || state_q == READ_ADD || state_q == READ_DATA) &&
                 phase_q != PH_HOLD))
                err_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = CHK_CMD;
                    phase_d = PH_RX;
                    sr_clr  = 1'b1;
                end
                CHK_CMD: begin
                    phase_d = PH_RX;
                    sr_clr  = 1'b1;
                    if (!MOSI)          state_d = WRITE;
                    else if (rd_seen_q) state_d = READ_DATA;
                    else                state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    case (phase_q)
                        PH_RX: begin
                            sr_shift = 1'b1;
                            if (rx_done) begin
                                rx_data_d  = frame_next;
                                rx_valid_d = 1'b1;
                                phase_d    = (state_q == READ_DATA) ? PH_WAIT_TX : PH_HOLD;
                                if (state_q == READ_ADD)
                                    rd_seen_d = 1'b1;
                                if (state_q != WRITE && frame_next[FRAME_W-1] != OP_RD_ADDR[1])
                                    err_d = 1'b1;
                            end
                        end
                        PH_WAIT_TX: begin
                            if (ram.tx_valid) begin
                                sr_load = 1'b1;
                                phase_d = PH_TX;
                            end
                        end
                        PH_TX: begin
                            sr_shift = 1'b1;
                            sr_din   = 1'b0;
                            miso_d   = ser_out;
                            if (tx_done) begin
                                phase_d   = PH_HOLD;
                                rd_seen_d = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ram.rx_data  = rx_data_q;
    assign ram.rx_valid = rx_valid_q;

`ifdef SPI_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err <= 1'b0;
        else        frame_err <= err_d;
    end
`else
    logic unused_err;
    assign unused_err = err_d;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - randomized self-checking bench for spi_slave_if against a frame-level model
module tb_spi_slave_if;
    import spi_pkg::*;

    localparam int DATA_W  = 8;
    localparam int FRAME_W = DATA_W + 2;

    logic clk = 1'b0;
    logic rst_n, SS_n, MOSI, MISO;
`ifdef SPI_FRAME_ERR_EN
    logic frame_err;
`endif

    spi_slave_if_if #(.DATA_W(DATA_W)) ram ();

    spi_slave_if #(.DATA_W(DATA_W), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .ram       (ram.slave)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Frame-level model: last delivered frame and whether a read address is pending
    logic [FRAME_W-1:0] m_rx;
    bit                 m_rd_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_err(input string tag, input bit exp);
`ifdef SPI_FRAME_ERR_EN
        check(tag, frame_err, exp);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        ram.tx_valid = 1'b0;
        tick();
        check("idle_miso", MISO, 0);
        check("idle_rx_valid", ram.rx_valid, 0);
        check("idle_rx_data", ram.rx_data, m_rx);
        chk_err("idle_err", 1'b0);
    endtask

    // nbits<FRAME_W aborts the receive; tx_abort 0 aborts while waiting, 1..8 before that bit;
    // rst_bit>=0 fires an async reset during that MISO bit
    task automatic run_frame(input bit cmd, input logic [FRAME_W-1:0] fr, input int nbits,
                             input int tx_abort, input int tx_delay, input logic [7:0] txd,
                             input int rst_bit);
        bit is_rdata;
        is_rdata = cmd && m_rd_seen;

        SS_n = 1'b0;
        MOSI = 1'b0;
        tick();
        check("start_rx_valid", ram.rx_valid, 0);

        MOSI = cmd;
        ram.tx_valid = 1'($urandom_range(0, 1));
        tick();
        check("cmd_miso", MISO, 0);

        for (int i = 0; i < nbits; i++) begin
            MOSI = fr[FRAME_W-1-i];
            ram.tx_valid = 1'($urandom_range(0, 1));
            ram.tx_data  = 8'($urandom);
            tick();
            check("rx_valid", ram.rx_valid, (i == FRAME_W - 1));
            check("rx_miso", MISO, 0);
            if (i == FRAME_W - 1) begin
                m_rx = fr;
                check("rx_data", ram.rx_data, m_rx);
                chk_err("cmd_mismatch", cmd && !fr[FRAME_W-1]);
            end
        end

        if (nbits < FRAME_W) begin
            SS_n = 1'b1;
            MOSI = fr[FRAME_W-1-nbits];
            tick();
            check("abort_rx_valid", ram.rx_valid, 0);
            check("abort_rx_data", ram.rx_data, m_rx);
            chk_err("abort_rx_err", 1'b1);
            MOSI = 1'b0;
            ram.tx_valid = 1'b0;
            return;
        end

        if (cmd && !m_rd_seen) m_rd_seen = 1'b1;
        ram.tx_valid = 1'b0;

        if (!is_rdata) begin
            for (int k = 0; k < 3; k++) begin
                ram.tx_valid = 1'($urandom_range(0, 1));
                tick();
                check("hold_miso", MISO, 0);
                check("hold_rx_valid", ram.rx_valid, 0);
            end
            end_frame();
            return;
        end

        for (int d = 0; d < tx_delay; d++) begin
            tick();
            check("wait_miso", MISO, 0);
            check("wait_rx_valid", ram.rx_valid, 0);
        end

        if (tx_abort == 0) begin
            SS_n = 1'b1;
            tick();
            check("abort_wait_miso", MISO, 0);
            chk_err("abort_wait_err", 1'b1);
            return;
        end

        ram.tx_valid = 1'b1;
        ram.tx_data  = txd;
        tick();
        check("latch_miso", MISO, 0);
        check("latch_rx_valid", ram.rx_valid, 0);
        ram.tx_valid = 1'b0;
        ram.tx_data  = 8'($urandom);

        for (int b = 0; b < DATA_W; b++) begin
            if (tx_abort == b + 1) begin
                SS_n = 1'b1;
                tick();
                check("abort_tx_miso", MISO, 0);
                chk_err("abort_tx_err", 1'b1);
                return;
            end
            tick();
            check("miso_bit", MISO, txd[DATA_W-1-b]);
            if (b == rst_bit) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_miso", MISO, 0);
                check("rst_rx_data", ram.rx_data, 0);
                check("rst_rx_valid", ram.rx_valid, 0);
                m_rx = '0;
                m_rd_seen = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                SS_n  = 1'b1;
                tick();
                return;
            end
        end
        m_rd_seen = 1'b0;

        tick();
        check("tx_end_miso", MISO, 0);
        end_frame();
    endtask

    initial begin
        rst_n = 1'b0;
        SS_n  = 1'b1;
        MOSI  = 1'b0;
        ram.tx_valid = 1'b0;
        ram.tx_data  = '0;
        m_rx = '0;
        m_rd_seen = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_miso", MISO, 0);
        check("reset_rx_data", ram.rx_data, 0);
        check("reset_rx_valid", ram.rx_valid, 0);
        chk_err("reset_err", 1'b0);
        rst_n = 1'b1;
        tick();

        run_frame(1'b0, {OP_WR_ADDR, 8'h0A}, FRAME_W, 9, 0, 8'h00, -1);
        run_frame(1'b0, {OP_WR_DATA, 8'hAA}, FRAME_W, 9, 0, 8'h00, -1);
        run_frame(1'b1, {OP_RD_ADDR, 8'h0A}, FRAME_W, 9, 0, 8'h00, -1);
        run_frame(1'b1, {OP_RD_DATA, 8'h00}, FRAME_W, 9, 2, 8'hAA, -1);
        run_frame(1'b0, {OP_WR_DATA, 8'h55}, 5, 9, 0, 8'h00, -1);
        run_frame(1'b0, {OP_WR_DATA, 8'h3C}, 9, 9, 0, 8'h00, -1);
        run_frame(1'b1, {OP_RD_ADDR, 8'h21}, FRAME_W, 9, 0, 8'h00, -1);
        run_frame(1'b1, {OP_RD_DATA, 8'h00}, FRAME_W, 9, 1, 8'hC3, 3);
        run_frame(1'b1, {OP_RD_ADDR, 8'h0B}, FRAME_W, 9, 0, 8'h00, -1);
        run_frame(1'b1, {OP_RD_DATA, 8'h00}, FRAME_W, 9, 0, 8'h5C, -1);

        for (int n = 0; n < 60; n++) begin
            bit                 cmd;
            logic [FRAME_W-1:0] fr;
            int                 nbits, tx_abort;
            cmd      = 1'($urandom_range(0, 1));
            fr       = FRAME_W'($urandom);
            nbits    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FRAME_W - 1)) : FRAME_W;
            tx_abort = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DATA_W)) : DATA_W + 1;
            run_frame(cmd, fr, nbits, tx_abort, int'($urandom_range(0, 3)), 8'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
